// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pkg : shared state and owner encodings for the memory arbiter    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    RESP    = 2'd3
  } mem_arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } mem_arb_owner_t;

  localparam int unsigned c_WAIT_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_timeout : 8-bit wait counter flagging a stalled memory access    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [c_WAIT_CNT_W-1:0] c_LAST_COUNT = c_WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_WAIT_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Enable already excludes mem_ready, so a same-cycle ready always wins.
  assign o_expired = i_enable && (r_count == c_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : fetch/data arbiter onto one memory port with timeout. |
// | Optional round-robin tie-break enabled by defining MEM_ARB_RR_EN.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_excpt,
  input  logic        d_req,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_excpt,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_excpt
);

  mem_arb_state_t r_state;
  logic        r_mem_req;
  logic [29:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_we;
  logic        r_if_done, r_if_excpt, r_d_done, r_d_excpt;
  logic [31:0] r_if_rdata, r_d_rdata;

  logic        w_busy;
  logic        w_expired;
  logic        w_grant_d;
  logic [31:0] w_resp_rdata;
  logic        w_resp_excpt;

  assign w_busy = (r_state == BUSY_IF) || (r_state == BUSY_D);

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_b    (rst_b),
    .i_clear  (!w_busy),
    .i_enable (w_busy && !mem_ready),
    .o_expired(w_expired)
  );

`ifdef MEM_ARB_RR_EN
  mem_arb_owner_t r_last_owner;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last_owner <= OWNER_IF;
    end else if (r_state == IDLE) begin
      if (w_grant_d) begin
        r_last_owner <= OWNER_D;
      end else if (if_req) begin
        r_last_owner <= OWNER_IF;
      end
    end
  end

  assign w_grant_d = d_req && (!if_req || (r_last_owner == OWNER_IF));
`else
  assign w_grant_d = d_req;
`endif

  // A timeout completes with a fault and no data.
  assign w_resp_rdata = mem_ready ? mem_rdata : 32'h0;
  assign w_resp_excpt = mem_ready ? mem_excpt : 1'b1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= '0;
      r_if_done   <= 1'b0;
      r_if_rdata  <= '0;
      r_if_excpt  <= 1'b0;
      r_d_done    <= 1'b0;
      r_d_rdata   <= '0;
      r_d_excpt   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state     <= BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_we    <= d_we;
          end else if (if_req) begin
            r_state     <= BUSY_IF;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_we    <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ready || w_expired) begin
            r_state     <= RESP;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= '0;
            if (r_state == BUSY_D) begin
              r_d_done  <= 1'b1;
              r_d_rdata <= w_resp_rdata;
              r_d_excpt <= w_resp_excpt;
            end else begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_resp_rdata;
              r_if_excpt <= w_resp_excpt;
            end
          end
        end
        RESP: begin
          r_state    <= IDLE;
          r_if_done  <= 1'b0;
          r_if_rdata <= '0;
          r_if_excpt <= 1'b0;
          r_d_done   <= 1'b0;
          r_d_rdata  <= '0;
          r_d_excpt  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign if_done   = r_if_done;
  assign if_rdata  = r_if_rdata;
  assign if_excpt  = r_if_excpt;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign d_excpt   = r_d_excpt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter (timeout=4)  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_excpt;
  logic        d_req = 1'b0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_we = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_excpt;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_excpt = 1'b0;

  int errors = 0;
  int checks = 0;
  int mem_wait = 0;
  bit mem_never = 1'b0;
  bit mem_fault = 1'b0;

  typedef struct {
    bit          is_d;
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          excpt;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_done  (if_done),
    .if_rdata (if_rdata),
    .if_excpt (if_excpt),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_we     (d_we),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .d_excpt  (d_excpt),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .mem_excpt(mem_excpt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [29:0] a);
    return (a == 30'h00100000) ? 32'h2402000A : {a, 2'b01};
  endfunction

  function automatic void push_grant(bit is_d, logic [29:0] a, logic [3:0] we, logic [31:0] wd);
    grant_t g;
    g.is_d = is_d; g.addr = a; g.we = we; g.wdata = wd;
    grant_q.push_back(g);
  endfunction

  function automatic void push_resp(bit is_d, logic [31:0] rd, bit ex);
    resp_t r;
    r.is_d = is_d; r.rdata = rd; r.excpt = ex;
    resp_q.push_back(r);
  endfunction

  // Memory model: answers after mem_wait BUSY cycles unless mem_never is set.
  task automatic mem_responder();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        mem_ready = !mem_never && (cnt == mem_wait);
        mem_rdata = rd_model(mem_addr);
        mem_excpt = mem_fault;
        cnt++;
      end else begin
        mem_ready = 1'b0;
        mem_excpt = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        cnt = 0;
      end
    end
  endtask

  task automatic scoreboard_monitor();
    grant_t g;
    resp_t  r;
    logic   prev_req = 1'b0;
    logic [69:0] got_v, exp_v;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        prev_req = 1'b0;
        continue;
      end
      if (mem_req && !prev_req) begin
        checks++;
        if (grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got addr=%h we=%h", mem_addr, mem_we);
        end else begin
          g = grant_q.pop_front();
          if (mem_addr !== g.addr || mem_we !== g.we || mem_wdata !== g.wdata) begin
            errors++;
            $display("FAIL grant_payload: got addr=%h we=%h wdata=%h expected addr=%h we=%h wdata=%h",
                     mem_addr, mem_we, mem_wdata, g.addr, g.we, g.wdata);
          end
        end
      end
      if (!mem_req) begin
        checks++;
        if ({mem_addr, mem_we, mem_wdata} !== 66'h0) begin
          errors++;
          $display("FAIL idle_payload: got addr=%h we=%h wdata=%h expected zeros", mem_addr, mem_we, mem_wdata);
        end
      end
      prev_req = mem_req;
      if (if_done || d_done) begin
        checks++;
        got_v = {if_done, if_rdata, if_excpt, d_done, d_rdata, d_excpt};
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got %h", got_v);
        end else begin
          r = resp_q.pop_front();
          exp_v = r.is_d ? {1'b0, 32'h0, 1'b0, 1'b1, r.rdata, r.excpt}
                         : {1'b1, r.rdata, r.excpt, 1'b0, 32'h0, 1'b0};
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL done_response: got %h expected %h", got_v, exp_v);
          end
        end
      end
    end
  endtask

  // Holds requests until their done pulse; redo_d keeps d_req high for new data accesses.
  task automatic service(input int budget, input int redo_d);
    int n = 0;
    while ((if_req || d_req || resp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (if_done) if_req = 1'b0;
      if (d_done) begin
        if (redo_d > 0) begin
          redo_d--;
          d_addr = d_addr + 30'h10;
        end else begin
          d_req = 1'b0;
        end
      end
    end
    checks++;
    if (if_req || d_req || resp_q.size() != 0) begin
      errors++;
      $display("FAIL service_timeout: got pending resp=%0d expected 0", resp_q.size());
      if_req = 1'b0;
      d_req  = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_we} !== 67'h0) begin
      errors++;
      $display("FAIL reset_mem: got req=%b addr=%h expected zeros", mem_req, mem_addr);
    end
    checks++;
    if ({if_done, if_rdata, if_excpt, d_done, d_rdata, d_excpt} !== 70'h0) begin
      errors++;
      $display("FAIL reset_resp: got if_done=%b d_done=%b expected zeros", if_done, d_done);
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'h00100000;
    push_grant(1'b0, 30'h00100000, 4'h0, 32'h0);
    push_resp(1'b0, 32'h2402000A, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL zw_mem_req: got %b expected 1", mem_req);
    end
    @(negedge clk);
    checks++;
    if (if_done !== 1'b1 || if_rdata !== 32'h2402000A) begin
      errors++;
      $display("FAIL zw_done: got done=%b rdata=%h expected 1 2402000a", if_done, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (if_done !== 1'b0) begin
      errors++;
      $display("FAIL zw_pulse: got %b expected 0", if_done);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'h200;
    d_req = 1'b1; d_addr = 30'h300; d_we = 4'hF; d_wdata = 32'hDEADBEEF;
    push_grant(1'b1, 30'h300, 4'hF, 32'hDEADBEEF);
    push_grant(1'b0, 30'h200, 4'h0, 32'h0);
    push_resp(1'b1, rd_model(30'h300), 1'b0);
    push_resp(1'b0, rd_model(30'h200), 1'b0);
    @(negedge clk);
    checks++;
    if (mem_we !== 4'hF || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sim_first: got we=%h wdata=%h expected f deadbeef", mem_we, mem_wdata);
    end
    service(40, 0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 30'h880 + 30'(r);
      d_req = 1'b1; d_addr = 30'h800 + 30'(r); d_we = 4'h3; d_wdata = 32'h1111_0000 + 32'(r);
      push_grant(1'b1, d_addr, 4'h3, d_wdata);
      push_grant(1'b0, if_addr, 4'h0, 32'h0);
      push_resp(1'b1, rd_model(d_addr), 1'b0);
      push_resp(1'b0, rd_model(if_addr), 1'b0);
      service(40, 0);
    end
  endtask

  task automatic test_rerequest();
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'h980;
    d_req = 1'b1; d_addr = 30'h900; d_we = 4'h0; d_wdata = 32'h0;
    push_grant(1'b1, 30'h900, 4'h0, 32'h0);
    push_resp(1'b1, rd_model(30'h900), 1'b0);
`ifdef MEM_ARB_RR_EN
    push_grant(1'b0, 30'h980, 4'h0, 32'h0);
    push_resp(1'b0, rd_model(30'h980), 1'b0);
    push_grant(1'b1, 30'h910, 4'h0, 32'h0);
    push_resp(1'b1, rd_model(30'h910), 1'b0);
`else
    push_grant(1'b1, 30'h910, 4'h0, 32'h0);
    push_resp(1'b1, rd_model(30'h910), 1'b0);
    push_grant(1'b0, 30'h980, 4'h0, 32'h0);
    push_resp(1'b0, rd_model(30'h980), 1'b0);
`endif
    service(60, 1);
  endtask

  task automatic test_wait_states();
    int req_cycles = 0;
    int done_at = 0;
    bit addr_ok = 1'b1;
    mem_wait = 3;
    @(negedge clk);
    d_req = 1'b1; d_addr = 30'h400; d_we = 4'h0; d_wdata = 32'h0;
    push_grant(1'b1, 30'h400, 4'h0, 32'h0);
    push_resp(1'b1, rd_model(30'h400), 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (mem_addr !== 30'h400) addr_ok = 1'b0;
        d_addr = 30'h3FF;
      end
      if (d_done && done_at == 0) begin
        done_at = k;
        d_req = 1'b0;
      end
    end
    mem_wait = 0;
    checks++;
    if (done_at != 5) begin
      errors++;
      $display("FAIL ws_latency: got done at N+%0d expected N+5", done_at);
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL ws_req_cycles: got %0d expected 4", req_cycles);
    end
    checks++;
    if (!addr_ok) begin
      errors++;
      $display("FAIL ws_payload_hold: got changed mem_addr expected 00000400");
    end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int done_at = 0;
    logic [31:0] got_rdata = 32'hX;
    logic got_excpt = 1'bX;
    mem_never = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'h500;
    push_grant(1'b0, 30'h500, 4'h0, 32'h0);
    push_resp(1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (if_done && done_at == 0) begin
        done_at = k;
        got_rdata = if_rdata;
        got_excpt = if_excpt;
        if_req = 1'b0;
      end
    end
    mem_never = 1'b0;
    checks++;
    if (done_at != 5 || req_cycles != 4) begin
      errors++;
      $display("FAIL to_latency: got done N+%0d busy=%0d expected N+5 busy=4", done_at, req_cycles);
    end
    checks++;
    if (got_excpt !== 1'b1 || got_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_result: got excpt=%b rdata=%h expected 1 00000000", got_excpt, got_rdata);
    end
    mem_fault = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_addr = 30'h600; d_we = 4'h0; d_wdata = 32'h0;
    push_grant(1'b1, 30'h600, 4'h0, 32'h0);
    push_resp(1'b1, rd_model(30'h600), 1'b1);
    service(20, 0);
    mem_fault = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    bit quiet = 1'b1;
    mem_never = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 30'h700;
    push_grant(1'b0, 30'h700, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy: got mem_req=%b expected 1", mem_req);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 30'h0 || if_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got req=%b addr=%h done=%b expected 0 0 0", mem_req, mem_addr, if_done);
    end
    if_req = 1'b0;
    mem_never = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if_done || d_done || mem_req) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL rst_release: got activity after reset expected idle");
    end
  endtask

  initial begin
    fork
      mem_responder();
      scoreboard_monitor();
      begin
        #200000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_zero_wait_fetch();
    test_simultaneous();
    test_back_to_back();
    test_rerequest();
    test_wait_states();
    test_timeout();
    test_reset_mid_busy();
    @(negedge clk);
    checks++;
    if (grant_q.size() != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got grants=%0d resps=%0d expected 0 0", grant_q.size(), resp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, 255: BUSY cycles without mem_ready before the transaction is aborted with an exception (range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the posedge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_done.
REQ-005 SHALL have port if_addr  input  30  fetch word address.
REQ-006 SHALL have port if_done  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  32  fetched word, valid while if_done=1.
REQ-008 SHALL have port if_excpt  output  1  fetch fault, valid while if_done=1.
REQ-009 SHALL have port d_req  input  1  data load/store request, held until d_done.
REQ-010 SHALL have port d_addr  input  30  data word address.
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_we  input  4  byte write mask; 0 means load.
REQ-013 SHALL have port d_done  output  1  one-cycle data completion pulse.
REQ-014 SHALL have port d_rdata  output  32  load data, valid while d_done=1.
REQ-015 SHALL have port d_excpt  output  1  data fault, valid while d_done=1.
REQ-016 SHALL have port mem_req  output  1  unified memory request.
REQ-017 SHALL have port mem_addr  output  30  memory word address.
REQ-018 SHALL have port mem_wdata  output  32  memory store data.
REQ-019 SHALL have port mem_we  output  4  memory byte write mask.
REQ-020 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-021 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-022 SHALL have port mem_excpt  input  1  memory address fault, valid with mem_ready.

Function
REQ-023 SHALL implement states IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE: d_req -> BUSY_D; else if_req -> BUSY_IF; else stay.
REQ-024 SHALL sample if_req and d_req only in IDLE; requests raised in any other state wait.
REQ-025 SHALL latch the winner's address, wdata and we on the IDLE->BUSY edge.
- A loser's payload is never latched; payload changes after grant are ignored.
REQ-026 SHALL drive mem_req=1 and the latched payload in BUSY_*; otherwise mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- For fetch grants, mem_we SHALL be 0 and mem_wdata SHALL be 0.
REQ-027 SHALL move BUSY_*->RESP on the edge where mem_ready=1, registering mem_rdata and mem_excpt.
REQ-028 SHALL, in RESP, pulse exactly the owner's *_done for one cycle with registered rdata/excpt, then go to IDLE.
- Non-owner done, rdata and excpt SHALL be 0.
REQ-029 SHALL give a 2-cycle zero-wait latency: req high in IDLE cycle N, mem_req in cycle N+1, done in cycle N+2 when mem_ready=1 in N+1.
REQ-030 SHALL run an 8-bit wait counter in BUSY_*, cleared on entry.
- At count==TIMEOUT_CYCLES-1 with mem_ready=0: go to RESP with excpt=1, rdata=0.
- mem_ready and timeout in the same cycle: mem_ready wins, no timeout.
REQ-031 SHALL require requesters to drop req by the edge ending RESP; req still high in the following IDLE is a new transaction.

Reset
REQ-032 SHALL on rst_b=0 immediately force IDLE, with all outputs 0, counter 0 and latched payload 0.
- mem_req drops asynchronously and an in-flight transaction is discarded without a done pulse.
REQ-033 SHALL resume arbitration on the first posedge after rst_b rises.

Configuration
REQ-034 SHALL, with MEM_ARB_RR_EN defined, break simultaneous if_req/d_req ties toward the requester not served last.
- Tracking uses a last-owner flag, reset to fetch, so the first tie goes to data.
REQ-035 SHALL, without MEM_ARB_RR_EN, use fixed data priority (REQ-023) and no last-owner register.

Structure
REQ-036 SHALL place the state enum (mem_arb_state_t) and owner encoding (OWNER_IF=0, OWNER_D=1) in shared package mem_arb_pkg.
REQ-037 SHALL implement the timeout in one sub-module, mem_arb_timeout (clear, enable, expired).

Verification
REQ-038 SHALL cover a zero-wait fetch: if_req, if_addr=0x00100000, mem_ready in the first BUSY cycle with mem_rdata=0x2402000A -> if_done 2 cycles after req with if_rdata=0x2402000A.
REQ-039 SHALL cover a simultaneous request without the macro: if_req and d_req, d_we=4'hF, d_wdata=0xDEADBEEF -> mem_we=4'hF first, d_done, then the fetch served.
REQ-040 SHALL cover a tie with MEM_ARB_RR_EN over two back-to-back rounds -> grant order data, fetch, data, fetch.
REQ-041 SHALL cover wait states: mem_ready delayed 3 cycles -> d_done in cycle N+5, mem_req high for exactly 4 cycles.
REQ-042 SHALL cover timeout: TIMEOUT_CYCLES=4, mem_ready never -> if_excpt=1 and if_rdata=0 after 4 BUSY cycles; also mem_excpt=1 with mem_ready -> d_excpt=1.
REQ-043 SHALL cover reset mid-BUSY: rst_b low -> mem_req=0 immediately, no done pulse, IDLE after release.
